// File: rtl/icache_mem_adapter_arb.sv
// Round-robin arbiter of NUM_CH fetch channels onto one registered memory request port,
// with credit-limited outstanding requests and an in-order response FIFO routed by channel ID.
module icache_mem_adapter_arb #(
   parameter  int NUM_CH    = 2,
   parameter  int ADDR_W    = 32,
   parameter  int DATA_W    = 256,
   parameter  int TAG_W     = 12,
   parameter  int MAX_OUTST = 8,
   parameter  int RSP_DEPTH = 4,
   localparam int CH_W      = $clog2(NUM_CH),
   localparam int CNT_W     = $clog2(MAX_OUTST) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_CH-1:0]        ch_req_vld,
   output logic [NUM_CH-1:0]        ch_req_rdy,
   input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
   input  logic [NUM_CH*TAG_W-1:0]  ch_req_tag,
   output logic [NUM_CH-1:0]        ch_rsp_vld,
   input  logic [NUM_CH-1:0]        ch_rsp_rdy,
   output logic [DATA_W-1:0]        ch_rsp_data,
   output logic [TAG_W-1:0]         ch_rsp_tag,
   output logic                     mem_req_vld,
   input  logic                     mem_req_rdy,
   output logic [ADDR_W-1:0]        mem_req_addr,
   output logic [CH_W+TAG_W-1:0]    mem_req_tag,
   input  logic                     mem_ack_vld,
   output logic                     mem_ack_rdy,
   input  logic [DATA_W-1:0]        mem_ack_data,
   input  logic [CH_W+TAG_W-1:0]    mem_ack_tag,
   output logic [CNT_W-1:0]         outst_cnt,
   output logic                     err_bad_ch
);

   // Every port is valid/ready: a transfer happens on a rising edge where both are high;
   // the sender holds its payload stable while valid is high and ready is low.

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int ENT_W = CH_W + TAG_W;

   logic [CH_W-1:0]     rr_ptr;
   logic [2*NUM_CH-1:0] vld_rot;
   logic                found, grant_any, can_issue;
   int                  win_int;
   logic [CH_W-1:0]     winner;
   logic [ADDR_W-1:0]   win_addr;
   logic [TAG_W-1:0]    win_tag;

   assign can_issue = (!mem_req_vld || mem_req_rdy) && (outst_cnt < CNT_W'(MAX_OUTST));

   // Rotate the request vector so bit 0 is the channel at rr_ptr; first set bit wins.
   always_comb begin
      vld_rot    = {ch_req_vld, ch_req_vld} >> rr_ptr;
      found      = 1'b0;
      win_int    = 0;
      ch_req_rdy = '0;
      win_addr   = '0;
      win_tag    = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (!found && vld_rot[k]) begin
            found   = 1'b1;
            win_int = (int'(rr_ptr) + k) % NUM_CH;
         end
      end
      grant_any = found && can_issue;
      winner    = CH_W'(win_int);
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_int == i) begin
            ch_req_rdy[i] = grant_any;
            win_addr      = ch_req_addr[i*ADDR_W +: ADDR_W];
            win_tag       = ch_req_tag[i*TAG_W +: TAG_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req_vld  <= 1'b0;
         mem_req_addr <= '0;
         mem_req_tag  <= '0;
         rr_ptr       <= '0;
      end else if (grant_any) begin
         mem_req_vld  <= 1'b1;
         mem_req_addr <= win_addr;
         mem_req_tag  <= {winner, win_tag};
         rr_ptr       <= CH_W'((win_int + 1) % NUM_CH);
      end else if (mem_req_rdy) begin
         mem_req_vld  <= 1'b0;
      end
   end

   logic [ENT_W-1:0]  fifo_tag  [RSP_DEPTH];
   logic [DATA_W-1:0] fifo_data [RSP_DEPTH];
   logic [PTR_W:0]    wr_ptr, rd_ptr;
   logic              fifo_empty, fifo_full, push, pop;
   logic [ENT_W-1:0]  head_ent;
   logic [CH_W-1:0]   head_ch;
   logic              head_bad, head_rdy;

   assign fifo_empty  = (wr_ptr == rd_ptr);
   assign fifo_full   = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign mem_ack_rdy = !fifo_full;
   assign push        = mem_ack_vld && !fifo_full;

   assign head_ent    = fifo_tag[rd_ptr[PTR_W-1:0]];
   assign head_ch     = head_ent[ENT_W-1 -: CH_W];
   assign head_bad    = {1'b0, head_ch} >= (CH_W+1)'(NUM_CH);
   assign ch_rsp_tag  = head_ent[TAG_W-1:0];
   assign ch_rsp_data = fifo_data[rd_ptr[PTR_W-1:0]];

   // A head entry with an out-of-range channel is discarded without presenting it.
   always_comb begin
      ch_rsp_vld = '0;
      head_rdy   = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!fifo_empty && !head_bad && (int'(head_ch) == i)) begin
            ch_rsp_vld[i] = 1'b1;
            head_rdy      = ch_rsp_rdy[i];
         end
      end
   end

   assign pop = !fifo_empty && (head_bad || head_rdy);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_tag[wr_ptr[PTR_W-1:0]]  <= mem_ack_tag;
         fifo_data[wr_ptr[PTR_W-1:0]] <= mem_ack_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         err_bad_ch <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (pop && head_bad) err_bad_ch <= 1'b1;
      end
   end

   // A credit is taken at grant (covering the request register) and returned when the response leaves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_cnt <= '0;
      end else begin
         case ({grant_any, pop})
            2'b10:   outst_cnt <= outst_cnt + 1'b1;
            2'b01:   if (outst_cnt != '0) outst_cnt <= outst_cnt - 1'b1;
            default: outst_cnt <= outst_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_mem_adapter_arb.sv
// Bench for icache_mem_adapter_arb: queue-based channel, memory and response-FIFO models
// compared against the DUT every cycle, plus directed scenarios with literal expectations.
module tb_icache_mem_adapter_arb;

   localparam int NUM_CH    = 3;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 64;
   localparam int TAG_W     = 12;
   localparam int MAX_OUTST = 8;
   localparam int RSP_DEPTH = 4;
   localparam int CH_W      = $clog2(NUM_CH);
   localparam int MT_W      = CH_W + TAG_W;
   localparam int CNT_W     = $clog2(MAX_OUTST) + 1;
   localparam int EW        = MT_W + DATA_W;

   logic                     clk, rst_n;
   logic [NUM_CH-1:0]        ch_req_vld, ch_req_rdy, ch_rsp_vld, ch_rsp_rdy;
   logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
   logic [NUM_CH*TAG_W-1:0]  ch_req_tag;
   logic [DATA_W-1:0]        ch_rsp_data, mem_ack_data;
   logic [TAG_W-1:0]         ch_rsp_tag;
   logic                     mem_req_vld, mem_req_rdy, mem_ack_vld, mem_ack_rdy, err_bad_ch;
   logic [ADDR_W-1:0]        mem_req_addr;
   logic [MT_W-1:0]          mem_req_tag, mem_ack_tag;
   logic [CNT_W-1:0]         outst_cnt;

   icache_mem_adapter_arb #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
      .MAX_OUTST(MAX_OUTST), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ch_req_vld(ch_req_vld), .ch_req_rdy(ch_req_rdy),
      .ch_req_addr(ch_req_addr), .ch_req_tag(ch_req_tag),
      .ch_rsp_vld(ch_rsp_vld), .ch_rsp_rdy(ch_rsp_rdy),
      .ch_rsp_data(ch_rsp_data), .ch_rsp_tag(ch_rsp_tag),
      .mem_req_vld(mem_req_vld), .mem_req_rdy(mem_req_rdy),
      .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
      .mem_ack_vld(mem_ack_vld), .mem_ack_rdy(mem_ack_rdy),
      .mem_ack_data(mem_ack_data), .mem_ack_tag(mem_ack_tag),
      .outst_cnt(outst_cnt), .err_bad_ch(err_bad_ch)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- bench state ----------------
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [TAG_W-1:0]  tag;
   } req_t;

   req_t                       chq [NUM_CH][$];  // pending requests per channel
   logic [ADDR_W+MT_W-1:0]     mem_pend[$];      // requests accepted by memory, not yet acked
   logic [EW-1:0]              exp_q[$];         // expected response FIFO contents {mtag, data}
   logic [TAG_W-1:0]           dlog[$];          // tags delivered to channels
   int                         glog[$];          // granted channel per grant

   bit                m_mvld, m_err;
   logic [ADDR_W-1:0] m_maddr;
   logic [MT_W-1:0]   m_mtag;
   int                m_cnt, m_rr;

   bit                d_mem_req_rdy;
   logic [NUM_CH-1:0] d_rsp_rdy;
   bit                auto_ack, rand_pick, ack_busy;
   int                ack_pct, bad_pct;
   logic [MT_W-1:0]   a_tag;
   logic [DATA_W-1:0] a_data;

   int n_cmp = 0;
   int n_fail = 0;

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
      return {a, ~a};
   endfunction

   task automatic add_req(input int ch, input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] t);
      req_t r;
      r.addr = a;
      r.tag  = t;
      chq[ch].push_back(r);
   endtask

   // Memory model: answer one accepted request (front, or random pick) and hold it until taken.
   task automatic start_ack(input bit corrupt);
      int idx;
      logic [ADDR_W+MT_W-1:0] ent;
      idx = rand_pick ? $urandom_range(0, mem_pend.size() - 1) : 0;
      ent = mem_pend[idx];
      mem_pend.delete(idx);
      a_tag  = ent[MT_W-1:0];
      a_data = mem_data(ent[MT_W +: ADDR_W]);
      if (corrupt) a_tag[MT_W-1 -: CH_W] = CH_W'(3);
      ack_busy = 1'b1;
   endtask

   // ---------------- driver ----------------
   task automatic apply_inputs();
      for (int i = 0; i < NUM_CH; i++) begin
         if (chq[i].size() > 0) begin
            ch_req_vld[i] = 1'b1;
            ch_req_addr[i*ADDR_W +: ADDR_W] = chq[i][0].addr;
            ch_req_tag[i*TAG_W +: TAG_W]    = chq[i][0].tag;
         end else begin
            ch_req_vld[i] = 1'b0;
            ch_req_addr[i*ADDR_W +: ADDR_W] = $urandom;
            ch_req_tag[i*TAG_W +: TAG_W]    = TAG_W'($urandom);
         end
      end
      mem_req_rdy = d_mem_req_rdy;
      ch_rsp_rdy  = d_rsp_rdy;
      if (auto_ack && !ack_busy && mem_pend.size() > 0 && $urandom_range(0, 99) < ack_pct)
         start_ack($urandom_range(0, 99) < bad_pct);
      mem_ack_vld  = ack_busy;
      mem_ack_tag  = a_tag;
      mem_ack_data = a_data;
   endtask

   // One cycle: drive, compare against the model, then advance the model across the clock edge.
   task automatic step();
      int eg, hch;
      bit can, full, bad, pop, push;
      logic [EW-1:0] head;
      logic [NUM_CH-1:0] exp_rdy, exp_rv;
      @(negedge clk);
      apply_inputs();
      #1;
      can = (!m_mvld || mem_req_rdy) && (m_cnt < MAX_OUTST);
      eg = -1;
      if (can) begin
         for (int k = 0; k < NUM_CH; k++)
            if (eg < 0 && ch_req_vld[(m_rr + k) % NUM_CH]) eg = (m_rr + k) % NUM_CH;
      end
      exp_rdy = '0;
      if (eg >= 0) exp_rdy[eg] = 1'b1;
      check("ch_req_rdy", 64'(ch_req_rdy), 64'(exp_rdy));
      check("mem_req_vld", 64'(mem_req_vld), 64'(m_mvld));
      if (m_mvld) begin
         check("mem_req_addr", 64'(mem_req_addr), 64'(m_maddr));
         check("mem_req_tag", 64'(mem_req_tag), 64'(m_mtag));
      end
      check("outst_cnt", 64'(outst_cnt), 64'(m_cnt));
      check("err_bad_ch", 64'(err_bad_ch), 64'(m_err));
      full = exp_q.size() >= RSP_DEPTH;
      check("mem_ack_rdy", 64'(mem_ack_rdy), 64'(!full));
      hch = -1; bad = 1'b0; exp_rv = '0; head = '0;
      if (exp_q.size() > 0) begin
         head = exp_q[0];
         hch  = int'(head[EW-1 -: CH_W]);
         bad  = hch >= NUM_CH;
         if (!bad) exp_rv[hch] = 1'b1;
      end
      check("ch_rsp_vld", 64'(ch_rsp_vld), 64'(exp_rv));
      if (hch >= 0 && !bad) begin
         check("ch_rsp_tag", 64'(ch_rsp_tag), 64'(head[DATA_W +: TAG_W]));
         check("ch_rsp_data", 64'(ch_rsp_data), 64'(head[DATA_W-1:0]));
      end
      // advance model
      if (m_mvld && mem_req_rdy) mem_pend.push_back({m_maddr, m_mtag});
      pop  = (hch >= 0) && (bad || ch_rsp_rdy[hch]);
      push = mem_ack_vld && !full;
      if (pop) begin
         if (bad) m_err = 1'b1;
         else     dlog.push_back(head[DATA_W +: TAG_W]);
         void'(exp_q.pop_front());
      end
      if (push) begin
         exp_q.push_back({mem_ack_tag, mem_ack_data});
         ack_busy = 1'b0;
      end
      if (eg >= 0) m_cnt++;
      if (pop && m_cnt > 0) m_cnt--;
      if (eg >= 0) begin
         m_mvld  = 1'b1;
         m_maddr = chq[eg][0].addr;
         m_mtag  = {CH_W'(eg), chq[eg][0].tag};
         void'(chq[eg].pop_front());
         m_rr = (eg + 1) % NUM_CH;
         glog.push_back(eg);
      end else if (mem_req_rdy) begin
         m_mvld = 1'b0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Async reset pulse in the middle of a cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst mem_req_vld", 64'(mem_req_vld), 64'd0);
      check("rst ch_rsp_vld", 64'(ch_rsp_vld), 64'd0);
      check("rst outst_cnt", 64'(outst_cnt), 64'd0);
      check("rst err_bad_ch", 64'(err_bad_ch), 64'd0);
      check("rst mem_ack_rdy", 64'(mem_ack_rdy), 64'd1);
      ch_req_vld = '0; mem_ack_vld = 1'b0; ch_rsp_rdy = '0; mem_req_rdy = 1'b0;
      #1;
      check("rst ch_req_rdy", 64'(ch_req_rdy), 64'd0);
      for (int i = 0; i < NUM_CH; i++) chq[i].delete();
      mem_pend.delete(); exp_q.delete(); dlog.delete(); glog.delete();
      m_mvld = 1'b0; m_err = 1'b0; m_maddr = '0; m_mtag = '0; m_cnt = 0; m_rr = 0;
      ack_busy = 1'b0; auto_ack = 1'b0; rand_pick = 1'b0; ack_pct = 0; bad_pct = 0;
      d_mem_req_rdy = 1'b1; d_rsp_rdy = '1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      ch_req_vld = '0; ch_req_addr = '0; ch_req_tag = '0; ch_rsp_rdy = '0;
      mem_req_rdy = 1'b0; mem_ack_vld = 1'b0; mem_ack_tag = '0; mem_ack_data = '0;
      a_tag = '0; a_data = '0;
      do_reset();

      // single ch0 request and its response
      add_req(0, 32'h1000, 12'h0A5);
      step();
      check("t1 grant", 64'(ch_req_rdy), 64'b001);
      step();
      check("t1 mem_req_vld", 64'(mem_req_vld), 64'd1);
      check("t1 mem_req_addr", 64'(mem_req_addr), 64'h1000);
      check("t1 mem_req_tag", 64'(mem_req_tag), 64'h0A5);
      check("t1 outst 1", 64'(outst_cnt), 64'd1);
      ack_busy = 1'b1; a_tag = 14'h0A5; a_data = 64'hDEAD_BEEF_0123_4567;
      void'(mem_pend.pop_front());
      step();
      step();
      check("t1 rsp_vld", 64'(ch_rsp_vld), 64'b001);
      check("t1 rsp_tag", 64'(ch_rsp_tag), 64'h0A5);
      check("t1 rsp_data", 64'(ch_rsp_data), 64'hDEAD_BEEF_0123_4567);
      step();
      check("t1 outst 0", 64'(outst_cnt), 64'd0);

      // two channels alternate, then the credit limit stops grants at MAX_OUTST
      do_reset();
      for (int i = 0; i < 6; i++) begin
         add_req(0, $urandom, TAG_W'($urandom));
         add_req(1, $urandom, TAG_W'($urandom));
      end
      run(12);
      check("t3 grant count", 64'(glog.size()), 64'(MAX_OUTST));
      for (int k = 0; k < 8 && k < glog.size(); k++)
         check("t2 rr order", 64'(glog[k]), 64'(k % 2));
      check("t3 rdy at limit", 64'(ch_req_rdy), 64'd0);
      start_ack(1'b0);
      run(6);
      check("t3 one more grant", 64'(glog.size()), 64'(MAX_OUTST + 1));

      // memory stall holds the request register, release grants in the same cycle
      do_reset();
      d_mem_req_rdy = 1'b0;
      add_req(0, 32'h2000, 12'h001);
      add_req(0, 32'h2004, 12'h002);
      add_req(0, 32'h2008, 12'h003);
      step();
      check("t4 first grant", 64'(ch_req_rdy), 64'b001);
      for (int i = 0; i < 5; i++) begin
         step();
         check("t4 stall no grant", 64'(ch_req_rdy), 64'd0);
         check("t4 stall addr", 64'(mem_req_addr), 64'h2000);
      end
      d_mem_req_rdy = 1'b1;
      step();
      check("t4 release grant", 64'(ch_req_rdy), 64'b001);
      step();
      check("t4 next addr", 64'(mem_req_addr), 64'h2004);

      // stalled ch1 fills the response FIFO, then drains in order
      do_reset();
      d_rsp_rdy = 3'b101;
      for (int i = 0; i < 5; i++) add_req(1, 32'h3000 + 32'(i * 4), 12'h010 + 12'(i));
      run(8);
      auto_ack = 1'b1; ack_pct = 100;
      run(10);
      check("t5 ack backpressure", 64'(mem_ack_rdy), 64'd0);
      check("t5 fifth ack waiting", 64'(mem_ack_vld), 64'd1);
      check("t5 head ch1", 64'(ch_rsp_vld), 64'b010);
      d_rsp_rdy = '1;
      run(10);
      check("t5 delivered count", 64'(dlog.size()), 64'd5);
      for (int i = 0; i < 5 && i < dlog.size(); i++)
         check("t5 delivery order", 64'(dlog[i]), 64'h010 + 64'(i));

      // acknowledgement carrying an invalid channel ID
      do_reset();
      add_req(2, 32'h4000, 12'h03C);
      run(3);
      start_ack(1'b1);
      step();
      step();
      check("t6 bad no rsp_vld", 64'(ch_rsp_vld), 64'd0);
      step();
      check("t6 err set", 64'(err_bad_ch), 64'd1);
      check("t6 credit back", 64'(outst_cnt), 64'd0);
      run(3);
      check("t6 err sticky", 64'(err_bad_ch), 64'd1);

      // randomized traffic with a reset pulse in the middle
      for (int phase = 0; phase < 2; phase++) begin
         do_reset();
         auto_ack = 1'b1; rand_pick = 1'b1; ack_pct = 40; bad_pct = 5;
         for (int c = 0; c < 1000; c++) begin
            for (int i = 0; i < NUM_CH; i++)
               if (chq[i].size() < 4 && $urandom_range(0, 99) < 30)
                  add_req(i, $urandom, TAG_W'($urandom));
            d_mem_req_rdy = ($urandom_range(0, 3) != 0);
            d_rsp_rdy     = NUM_CH'($urandom);
            step();
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
